parser_field_serializer: RTL and testbench

Downstream stage of the packet field parser. It captures the per-packet field vector on the parser's all-values-ready strobe and buffers each capture as one record in a small FIFO. It then streams the fields out one per beat over a valid/ready interface, so a narrow consumer (CSR logger, lookup engine) can read parse results without stalling the parser. Records that arrive while the buffer is full are dropped and counted.

---
 rtl/parser_field_serializer_if.sv | 33 +++
 rtl/parser_field_serializer.sv | 161 ++++++++++++++++
 tb/tb_parser_field_serializer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/parser_field_serializer_if.sv
// Capture-side and stream-side signals of the field serializer.
// The slave modport is the serializer's view; the master modport is the producer/consumer view.
interface parser_field_serializer_if #(
  parameter int unsigned FIELD_NUMBER   = 4,
  parameter int unsigned FIELD_SIZE_MAX = 4
);
  localparam int unsigned W  = FIELD_SIZE_MAX * 8;
  localparam int unsigned IW = (FIELD_NUMBER > 1) ? $clog2(FIELD_NUMBER) : 1;

  logic                      In_AllValues_Ready;
  logic [FIELD_NUMBER-1:0]   In_Valid;
  logic [FIELD_NUMBER*W-1:0] In_Field;
  logic [FIELD_NUMBER-1:0]   In_Error;

  logic                      Out_Valid;
  logic                      Out_Ready;
  logic [W-1:0]              Out_Field;
  logic [IW-1:0]             Out_Index;
  logic                      Out_FieldValid;
  logic                      Out_Error;
  logic                      Out_Sop;
  logic                      Out_Eop;

  modport slave (
    input  In_AllValues_Ready, In_Valid, In_Field, In_Error, Out_Ready,
    output Out_Valid, Out_Field, Out_Index, Out_FieldValid, Out_Error, Out_Sop, Out_Eop
  );

  modport master (
    output In_AllValues_Ready, In_Valid, In_Field, In_Error, Out_Ready,
    input  Out_Valid, Out_Field, Out_Index, Out_FieldValid, Out_Error, Out_Sop, Out_Eop
  );
endinterface

// File: rtl/parser_field_serializer.sv
// Buffers parsed field vectors as records in a small FIFO and streams them out
// one field per valid/ready beat; records arriving while full are dropped and counted.
module parser_field_serializer #(
  parameter int unsigned FIELD_NUMBER   = 4,
  parameter int unsigned FIELD_SIZE_MAX = 4,
  parameter int unsigned FIFO_DEPTH     = 2
) (
  input  logic                        Clk,
  input  logic                        Rst,
  parser_field_serializer_if.slave    bus,
  output logic [15:0]                 Drop_Count,
  output logic                        Busy
);
  localparam int unsigned W  = FIELD_SIZE_MAX * 8;
  localparam int unsigned IW = (FIELD_NUMBER > 1) ? $clog2(FIELD_NUMBER) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned FW = FIELD_NUMBER * W;
  localparam logic [IW-1:0] LAST_IDX = IW'(FIELD_NUMBER - 1);

  typedef enum logic {IDLE, SEND} state_e;

  logic [FW-1:0]           field_mem [FIFO_DEPTH];
  logic [FIELD_NUMBER-1:0] valid_mem [FIFO_DEPTH];
  logic [FIELD_NUMBER-1:0] error_mem [FIFO_DEPTH];

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   drop_q, drop_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_field_q, out_field_d;
  logic [IW-1:0] out_index_q, out_index_d;
  logic          out_fvalid_q, out_fvalid_d;
  logic          out_error_q, out_error_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;

  logic                    hs_c, pop_c, push_c, bypass_c, load_c;
  logic [FW-1:0]           head_field_c;
  logic [FIELD_NUMBER-1:0] head_valid_c, head_error_c;

  // Record storage; no reset needed since pointers and count gate every read.
  always_ff @(posedge Clk) begin
    if (push_c) begin
      field_mem[wr_ptr_q] <= bus.In_Field;
      valid_mem[wr_ptr_q] <= bus.In_Valid;
      error_mem[wr_ptr_q] <= bus.In_Error;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_q       <= '0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_field_q  <= '0;
      out_index_q  <= '0;
      out_fvalid_q <= 1'b0;
      out_error_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_field_q  <= out_field_d;
      out_index_q  <= out_index_d;
      out_fvalid_q <= out_fvalid_d;
      out_error_q  <= out_error_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drop_d       = drop_q;
    out_field_d  = out_field_q;
    out_index_d  = out_index_q;
    out_fvalid_d = out_fvalid_q;
    out_error_d  = out_error_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;

    hs_c   = (state_q == SEND) && bus.Out_Ready;
    pop_c  = hs_c && (idx_q == LAST_IDX);
    // A full buffer still takes a record when the head leaves on the same edge.
    push_c = bus.In_AllValues_Ready && ((count_q < CW'(FIFO_DEPTH)) || pop_c);

    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    if (bus.In_AllValues_Ready && !push_c && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
    busy_d = (count_d != '0);

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (hs_c) begin
          if (!pop_c) begin
            idx_d = idx_q + IW'(1);
          end else begin
            idx_d   = '0;
            state_d = (count_d != '0) ? SEND : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The next head may be the record being written this very edge.
    bypass_c     = push_c && (wr_ptr_q == rd_ptr_d);
    head_field_c = bypass_c ? bus.In_Field : field_mem[rd_ptr_d];
    head_valid_c = bypass_c ? bus.In_Valid : valid_mem[rd_ptr_d];
    head_error_c = bypass_c ? bus.In_Error : error_mem[rd_ptr_d];

    out_valid_d = (state_d == SEND);
    load_c      = (state_d == SEND) && ((state_q == IDLE) || hs_c);
    if (load_c) begin
      out_field_d  = head_field_c[32'(idx_d) * W +: W];
      out_index_d  = idx_d;
      out_fvalid_d = head_valid_c[idx_d];
      out_error_d  = head_error_c[idx_d];
      out_sop_d    = (idx_d == '0);
      out_eop_d    = (idx_d == LAST_IDX);
    end
  end

  assign bus.Out_Valid      = out_valid_q;
  assign bus.Out_Field      = out_field_q;
  assign bus.Out_Index      = out_index_q;
  assign bus.Out_FieldValid = out_fvalid_q;
  assign bus.Out_Error      = out_error_q;
  assign bus.Out_Sop        = out_sop_q;
  assign bus.Out_Eop        = out_eop_q;
  assign Drop_Count         = drop_q;
  assign Busy               = busy_q;
endmodule

// File: tb/tb_parser_field_serializer.sv
// Directed bench for parser_field_serializer: 4 fields of 32 bits, 2-deep record FIFO.
module tb_parser_field_serializer;
  localparam int unsigned FN = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] Drop_Count;
  logic        Busy;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 Clk = ~Clk;

  parser_field_serializer_if #(.FIELD_NUMBER(4), .FIELD_SIZE_MAX(4)) bus ();

  parser_field_serializer #(.FIELD_NUMBER(4), .FIELD_SIZE_MAX(4), .FIFO_DEPTH(2)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus), .Drop_Count(Drop_Count), .Busy(Busy)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input logic [31:0] base);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = base + 32'(i);
    return r;
  endfunction

  // Present one record for exactly one capture edge.
  task automatic push_rec(input logic [127:0] f, input logic [3:0] v, input logic [3:0] e);
    bus.In_AllValues_Ready = 1'b1;
    bus.In_Field = f;
    bus.In_Valid = v;
    bus.In_Error = e;
    step();
    bus.In_AllValues_Ready = 1'b0;
    bus.In_Field = '0;
    bus.In_Valid = '0;
    bus.In_Error = '0;
  endtask

  task automatic test_reset();
    logic [41:0] got;
    Rst = 1'b1;
    step();
    step();
    got = {bus.Out_Valid, bus.Out_Field, bus.Out_Index, bus.Out_FieldValid,
           bus.Out_Error, bus.Out_Sop, bus.Out_Eop, Busy, 2'b00};
    total_cnt++;
    if (got !== 42'd0) $display("FAIL reset_outputs: got %h exp 0", got);
    else pass_cnt++;
    total_cnt++;
    if (Drop_Count !== 16'h0000) $display("FAIL reset_drop: got %h exp 0000", Drop_Count);
    else pass_cnt++;
    Rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0]  v = 4'b1011;
    logic [3:0]  e = 4'b0100;
    logic [39:0] got, exp;
    bus.Out_Ready = 1'b1;
    push_rec({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, v, e);
    total_cnt++;
    if (bus.Out_Valid !== 1'b0 || Busy !== 1'b1)
      $display("FAIL single_edgeN: valid %b busy %b exp valid 0 busy 1", bus.Out_Valid, Busy);
    else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      step();
      got = {bus.Out_Valid, bus.Out_Index, bus.Out_Field, bus.Out_FieldValid,
             bus.Out_Error, bus.Out_Sop, bus.Out_Eop};
      exp = {1'b1, 2'(b), 32'h11111111 * 32'(b + 1), v[b], e[b], (b == 0), (b == 3)};
      total_cnt++;
      if (got !== exp) $display("FAIL single_beat%0d: got %h exp %h", b, got, exp);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (bus.Out_Valid !== 1'b0 || Busy !== 1'b0)
      $display("FAIL single_end: valid %b busy %b exp 0 0", bus.Out_Valid, Busy);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int   seen = 0;
    logic rdy;
    bus.Out_Ready = 1'b0;
    push_rec(mk(32'hA0000000), 4'b1111, 4'b0000);
    for (int cyc = 0; cyc < 40 && seen < 4; cyc++) begin
      rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      bus.Out_Ready = rdy;
      if (bus.Out_Valid) begin
        total_cnt++;
        if ({bus.Out_Index, bus.Out_Field} !== {2'(seen), 32'hA0000000 + 32'(seen)})
          $display("FAIL bp_beat cyc%0d: got idx %0d field %h exp idx %0d field %h",
                   cyc, bus.Out_Index, bus.Out_Field, seen, 32'hA0000000 + 32'(seen));
        else pass_cnt++;
        if (rdy) seen++;
      end
      step();
    end
    bus.Out_Ready = 1'b0;
    total_cnt++;
    if (seen != 4 || bus.Out_Valid !== 1'b0)
      $display("FAIL bp_total: handshakes %0d valid %b exp 4 and 0", seen, bus.Out_Valid);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int          got = 0;
    logic [31:0] ef;
    bus.Out_Ready = 1'b0;
    push_rec(mk(32'h0A000000), 4'b1111, 4'b0000);
    push_rec(mk(32'h0B000000), 4'b1111, 4'b0000);
    push_rec(mk(32'h0C000000), 4'b1111, 4'b0000);
    total_cnt++;
    if (Drop_Count !== 16'd1 || Busy !== 1'b1)
      $display("FAIL ovf_drop: drop %0d busy %b exp 1 1", Drop_Count, Busy);
    else pass_cnt++;
    bus.Out_Ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got < 8; cyc++) begin
      if (bus.Out_Valid) begin
        ef = ((got < 4) ? 32'h0A000000 : 32'h0B000000) + 32'(got % 4);
        total_cnt++;
        if ({bus.Out_Index, bus.Out_Field, bus.Out_Sop} !== {2'(got % 4), ef, (got % 4) == 0})
          $display("FAIL ovf_beat%0d: got idx %0d field %h sop %b exp idx %0d field %h",
                   got, bus.Out_Index, bus.Out_Field, bus.Out_Sop, got % 4, ef);
        else pass_cnt++;
        got++;
      end
      step();
    end
    total_cnt++;
    if (got != 8 || Drop_Count !== 16'd1)
      $display("FAIL ovf_total: beats %0d drop %0d exp 8 1", got, Drop_Count);
    else pass_cnt++;
  endtask

  task automatic test_full_pop();
    logic [31:0] base [4];
    logic [31:0] ef;
    base = '{32'h1A000000, 32'h1B000000, 32'h1C000000, 32'h1D000000};
    bus.Out_Ready = 1'b0;
    push_rec(mk(base[0]), 4'b1111, 4'b0000);
    push_rec(mk(base[1]), 4'b1111, 4'b0000);
    bus.Out_Ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      bus.In_AllValues_Ready = (b == 3) || (b == 7);
      bus.In_Field = (b == 3) ? mk(base[2]) : mk(base[3]);
      bus.In_Valid = 4'b1111;
      ef = base[b / 4] + 32'(b % 4);
      total_cnt++;
      if ({bus.Out_Valid, bus.Out_Index, bus.Out_Field} !== {1'b1, 2'(b % 4), ef})
        $display("FAIL fullpop_beat%0d: got v %b idx %0d field %h exp v 1 idx %0d field %h",
                 b, bus.Out_Valid, bus.Out_Index, bus.Out_Field, b % 4, ef);
      else pass_cnt++;
      step();
    end
    bus.In_AllValues_Ready = 1'b0;
    total_cnt++;
    if (bus.Out_Valid !== 1'b0 || Drop_Count !== 16'd1 || Busy !== 1'b0)
      $display("FAIL fullpop_end: valid %b drop %0d busy %b exp 0 1 0",
               bus.Out_Valid, Drop_Count, Busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bus.Out_Ready = 1'b0;
    push_rec(mk(32'h2A000000), 4'b1111, 4'b0000);
    push_rec(mk(32'h2B000000), 4'b1111, 4'b0000);
    bus.Out_Ready = 1'b1;
    step();
    step();
    total_cnt++;
    if (bus.Out_Valid !== 1'b1 || bus.Out_Index !== 2'd2)
      $display("FAIL rstmid_pre: valid %b idx %0d exp 1 2", bus.Out_Valid, bus.Out_Index);
    else pass_cnt++;
    Rst = 1'b1;
    bus.Out_Ready = 1'b0;
    step();
    Rst = 1'b0;
    total_cnt++;
    if (bus.Out_Valid !== 1'b0 || Busy !== 1'b0 || Drop_Count !== 16'd0 || bus.Out_Index !== 2'd0)
      $display("FAIL rstmid_after: valid %b busy %b drop %0d idx %0d exp 0 0 0 0",
               bus.Out_Valid, Busy, Drop_Count, bus.Out_Index);
    else pass_cnt++;
    bus.Out_Ready = 1'b1;
    push_rec(mk(32'h2C000000), 4'b0001, 4'b0000);
    total_cnt++;
    if (bus.Out_Valid !== 1'b0)
      $display("FAIL rstmid_edgeN: valid %b exp 0", bus.Out_Valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({bus.Out_Valid, bus.Out_Index, bus.Out_Field, bus.Out_FieldValid} !== {1'b1, 2'd0, 32'h2C000000, 1'b1})
      $display("FAIL rstmid_fresh: got v %b idx %0d field %h fv %b exp 1 0 2c000000 1",
               bus.Out_Valid, bus.Out_Index, bus.Out_Field, bus.Out_FieldValid);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) step();
    total_cnt++;
    if (bus.Out_Valid !== 1'b0 || Busy !== 1'b0)
      $display("FAIL rstmid_drain: valid %b busy %b exp 0 0", bus.Out_Valid, Busy);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    bus.Out_Ready = 1'b0;
    bus.In_AllValues_Ready = 1'b1;
    bus.In_Field = mk(32'h30000000);
    bus.In_Valid = 4'b1111;
    for (int i = 0; i < 65536; i++) step();
    total_cnt++;
    if (Drop_Count !== 16'hFFFE) $display("FAIL sat_near: got %h exp fffe", Drop_Count);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) step();
    bus.In_AllValues_Ready = 1'b0;
    total_cnt++;
    if (Drop_Count !== 16'hFFFF) $display("FAIL sat_hold: got %h exp ffff", Drop_Count);
    else pass_cnt++;
    total_cnt++;
    if ({bus.Out_Valid, bus.Out_Index, bus.Out_Field} !== {1'b1, 2'd0, 32'h30000000})
      $display("FAIL sat_head: got v %b idx %0d field %h exp 1 0 30000000",
               bus.Out_Valid, bus.Out_Index, bus.Out_Field);
    else pass_cnt++;
  endtask

  initial begin
    Rst = 1'b1;
    bus.In_AllValues_Ready = 1'b0;
    bus.In_Field = '0;
    bus.In_Valid = '0;
    bus.In_Error = '0;
    bus.Out_Ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d done", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end
endmodule
